// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational 64-bit ALU between the execute stage (requester 0)
// and address generation (requester 1): grant -> registered issue -> per-requester response slot.
module alu_share_arbiter #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_cntrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  input  logic             alu_carry_out,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result0,
  output logic [WIDTH-1:0] rsp_result1,
  output logic [3:0]       rsp_flags0,
  output logic [3:0]       rsp_flags1,
  output logic [1:0]       rsp_err,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  // Opcodes 001 and 111 have no ALU meaning; they are answered with an error response.
  function automatic logic op_legal(input logic [2:0] op);
    return !(op == 3'b001 || op == 3'b111);
  endfunction

  // Issue stage: issue_valid_q marks an op presented to the ALU, issue_err_q an illegal
  // op travelling through the same slot so its error response keeps the normal latency.
  logic             issue_valid_q, issue_valid_d;
  logic             issue_err_q,   issue_err_d;
  logic             issue_owner_q, issue_owner_d;
  logic [WIDTH-1:0] alu_a_q,       alu_a_d;
  logic [WIDTH-1:0] alu_b_q,       alu_b_d;
  logic [2:0]       alu_cntrl_q,   alu_cntrl_d;
  logic             ptr_q,         ptr_d;

  logic [1:0]                  rsp_valid_q,  rsp_valid_d;
  logic [1:0]                  rsp_err_q,    rsp_err_d;
  logic [1:0][WIDTH-1:0]       rsp_result_q, rsp_result_d;
  logic [1:0][3:0]             rsp_flags_q,  rsp_flags_d;
  logic [1:0][CNT_W-1:0]       cnt_q,        cnt_d;

  logic [1:0]       elig;
  logic [1:0]       grant;
  logic             gnt_idx;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [3:0]       alu_flags;

  assign alu_flags = {alu_negative, alu_zero, alu_overflow, alu_carry_out};

  // NOTE: every signal assigned in an always_comb gets a default at the top of the block,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    elig = '0;
    for (int i = 0; i < 2; i++) begin
      elig[i] = req_valid[i] && !rsp_valid_q[i] &&
                !((issue_valid_q || issue_err_q) && (issue_owner_q == 1'(i)));
    end

    grant = 2'b00;
    unique case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase

    gnt_idx = grant[1];
    sel_op  = gnt_idx ? req_op1 : req_op0;
    sel_a   = gnt_idx ? req_a1  : req_a0;
    sel_b   = gnt_idx ? req_b1  : req_b0;
  end

  always_comb begin
    issue_valid_d = 1'b0;
    issue_err_d   = 1'b0;
    issue_owner_d = issue_owner_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_cntrl_d   = alu_cntrl_q;
    ptr_d         = ptr_q;

    if (grant != 2'b00) begin
      issue_owner_d = gnt_idx;
      ptr_d         = !gnt_idx;
      if (op_legal(sel_op)) begin
        issue_valid_d = 1'b1;
        alu_a_d       = sel_a;
        alu_b_d       = sel_b;
        alu_cntrl_d   = sel_op;
      end else begin
        // Illegal ops never reach the ALU; its inputs keep the last legal operation.
        issue_err_d = 1'b1;
      end
    end
  end

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_err_d    = rsp_err_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    cnt_d        = cnt_q;

    for (int i = 0; i < 2; i++) begin
      if (issue_valid_q && (issue_owner_q == 1'(i))) begin
        rsp_valid_d[i]  = 1'b1;
        rsp_err_d[i]    = 1'b0;
        rsp_result_d[i] = alu_result;
        rsp_flags_d[i]  = alu_flags;
      end else if (issue_err_q && (issue_owner_q == 1'(i))) begin
        rsp_valid_d[i]  = 1'b1;
        rsp_err_d[i]    = 1'b1;
        rsp_result_d[i] = '0;
        rsp_flags_d[i]  = '0;
      end else if (rsp_valid_q[i] && rsp_ready[i]) begin
        // Result and flags stay visible after the handshake; only the qualifiers drop.
        rsp_valid_d[i] = 1'b0;
        rsp_err_d[i]   = 1'b0;
      end

      if (grant[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_valid_q <= 1'b0;
      issue_err_q   <= 1'b0;
      issue_owner_q <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_cntrl_q   <= 3'b000;
      ptr_q         <= 1'b0;
      rsp_valid_q   <= '0;
      rsp_err_q     <= '0;
      rsp_result_q  <= '0;
      rsp_flags_q   <= '0;
      cnt_q         <= '0;
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_err_q   <= issue_err_d;
      issue_owner_q <= issue_owner_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_cntrl_q   <= alu_cntrl_d;
      ptr_q         <= ptr_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_result_q  <= rsp_result_d;
      rsp_flags_q   <= rsp_flags_d;
      cnt_q         <= cnt_d;
    end
  end

  assign req_ready   = grant;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_cntrl   = alu_cntrl_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_result0 = rsp_result_q[0];
  assign rsp_result1 = rsp_result_q[1];
  assign rsp_flags0  = rsp_flags_q[0];
  assign rsp_flags1  = rsp_flags_q[1];
  assign grant_cnt0  = cnt_q[0];
  assign grant_cnt1  = cnt_q[1];

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a small combinational ALU model closes the loop and
// each scenario task checks hand-computed values inline.
module tb_alu_share_arbiter;
  localparam int WIDTH = 64;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       req_valid, req_ready;
  logic [WIDTH-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [2:0]       req_op0, req_op1;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [2:0]       alu_cntrl;
  logic             alu_negative, alu_zero, alu_overflow, alu_carry_out;
  logic [1:0]       rsp_valid, rsp_ready, rsp_err;
  logic [WIDTH-1:0] rsp_result0, rsp_result1;
  logic [3:0]       rsp_flags0, rsp_flags1;
  logic [CNT_W-1:0] grant_cnt0, grant_cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = !clk;

  alu_share_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl),
    .alu_result(alu_result), .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result0(rsp_result0), .rsp_result1(rsp_result1),
    .rsp_flags0(rsp_flags0), .rsp_flags1(rsp_flags1),
    .rsp_err(rsp_err), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  // External ALU: 000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor.
  logic [WIDTH:0] sum;
  always_comb begin
    sum          = '0;
    alu_overflow = 1'b0;
    case (alu_cntrl)
      3'b000: sum = {1'b0, alu_b};
      3'b010: begin
        sum          = {1'b0, alu_a} + {1'b0, alu_b};
        alu_overflow = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1] != alu_a[WIDTH-1]);
      end
      3'b011: begin
        sum          = {1'b0, alu_a} + {1'b0, ~alu_b} + 65'd1;
        alu_overflow = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (sum[WIDTH-1] != alu_a[WIDTH-1]);
      end
      3'b100: sum = {1'b0, alu_a & alu_b};
      3'b101: sum = {1'b0, alu_a | alu_b};
      3'b110: sum = {1'b0, alu_a ^ alu_b};
      default: sum = '0;
    endcase
    alu_result    = sum[WIDTH-1:0];
    alu_carry_out = sum[WIDTH];
    alu_negative  = sum[WIDTH-1];
    alu_zero      = (sum[WIDTH-1:0] == '0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_req_ready got=%b want=00", req_ready); end
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL reset_rsp_valid got=%b want=00", rsp_valid); end
    n_cmp++; if (rsp_err !== 2'b00) begin n_bad++; $display("FAIL reset_rsp_err got=%b want=00", rsp_err); end
    n_cmp++; if (alu_a !== 64'd0 || alu_b !== 64'd0) begin n_bad++; $display("FAIL reset_alu_ab got=%h/%h want=0/0", alu_a, alu_b); end
    n_cmp++; if (alu_cntrl !== 3'b000) begin n_bad++; $display("FAIL reset_alu_cntrl got=%b want=000", alu_cntrl); end
    n_cmp++; if (grant_cnt0 !== 2'd0 || grant_cnt1 !== 2'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", grant_cnt0, grant_cnt1); end
    n_cmp++; if (rsp_result0 !== 64'd0 || rsp_flags1 !== 4'd0) begin n_bad++; $display("FAIL reset_slot got=%h/%b want=0/0000", rsp_result0, rsp_flags1); end
    @(negedge clk) reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_add();
    rsp_ready = 2'b11; req_valid = 2'b01; req_op0 = 3'b010; req_a0 = 64'd5; req_b0 = 64'd7;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL add_grant got=%b want=01", req_ready); end
    tick(); req_valid = 2'b00;
    n_cmp++; if (alu_cntrl !== 3'b010 || alu_a !== 64'd5 || alu_b !== 64'd7) begin n_bad++; $display("FAIL add_issue got=%b %h %h want=010 5 7", alu_cntrl, alu_a, alu_b); end
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL add_early_rsp got=%b want=00", rsp_valid); end
    n_cmp++; if (grant_cnt0 !== 2'd1) begin n_bad++; $display("FAIL add_cnt got=%0d want=1", grant_cnt0); end
    tick();
    n_cmp++; if (rsp_valid !== 2'b01) begin n_bad++; $display("FAIL add_rsp_valid got=%b want=01", rsp_valid); end
    n_cmp++; if (rsp_result0 !== 64'd12 || rsp_flags0 !== 4'b0000 || rsp_err !== 2'b00) begin n_bad++; $display("FAIL add_result got=%h %b %b want=c 0000 00", rsp_result0, rsp_flags0, rsp_err); end
    tick();
    n_cmp++; if (rsp_valid !== 2'b00 || rsp_result0 !== 64'd12) begin n_bad++; $display("FAIL add_consumed got=%b %h want=00 c", rsp_valid, rsp_result0); end
  endtask

  task automatic test_reset_midrun();
    req_valid = 2'b01; req_op0 = 3'b011; req_a0 = 64'd9; req_b0 = 64'd4;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL midrun_grant got=%b want=01", req_ready); end
    tick(); req_valid = 2'b00;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (alu_cntrl !== 3'b000 || alu_a !== 64'd0 || alu_b !== 64'd0) begin n_bad++; $display("FAIL midrun_alu got=%b %h %h want=000 0 0", alu_cntrl, alu_a, alu_b); end
    n_cmp++; if (rsp_result0 !== 64'd0 || grant_cnt0 !== 2'd0 || rsp_valid !== 2'b00) begin n_bad++; $display("FAIL midrun_state got=%h %0d %b want=0 0 00", rsp_result0, grant_cnt0, rsp_valid); end
    @(negedge clk) reset_n = 1'b1;
    tick(); tick();
    n_cmp++; if (rsp_valid !== 2'b00) begin n_bad++; $display("FAIL midrun_discard got=%b want=00", rsp_valid); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_rdy [6];
    exp_rdy = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
    rsp_ready = 2'b11; req_valid = 2'b11;
    req_op0 = 3'b010; req_a0 = 64'd1; req_b0 = 64'd2;
    req_op1 = 3'b011; req_a1 = 64'd0; req_b1 = 64'd1;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_cmp++; if (req_ready !== exp_rdy[k]) begin n_bad++; $display("FAIL contention_grant[%0d] got=%b want=%b", k, req_ready, exp_rdy[k]); end
      if (k == 2) begin
        n_cmp++; if (rsp_valid !== 2'b01 || rsp_result0 !== 64'd3 || rsp_flags0 !== 4'b0000) begin n_bad++; $display("FAIL contention_r0 got=%b %h %b want=01 3 0000", rsp_valid, rsp_result0, rsp_flags0); end
      end
      if (k == 3) begin
        n_cmp++; if (rsp_valid !== 2'b10 || rsp_result1 !== 64'hFFFF_FFFF_FFFF_FFFF || rsp_flags1 !== 4'b1000) begin n_bad++; $display("FAIL contention_r1 got=%b %h %b want=10 ffffffffffffffff 1000", rsp_valid, rsp_result1, rsp_flags1); end
      end
      tick();
    end
    req_valid = 2'b00;
    n_cmp++; if (grant_cnt0 !== 2'd2 || grant_cnt1 !== 2'd2) begin n_bad++; $display("FAIL contention_cnt got=%0d/%0d want=2/2", grant_cnt0, grant_cnt1); end
    tick(); tick();
  endtask

  task automatic test_overflow();
    req_valid = 2'b01; req_op0 = 3'b010; req_a0 = 64'h7FFF_FFFF_FFFF_FFFF; req_b0 = 64'd1;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL ovf_grant got=%b want=01", req_ready); end
    tick(); req_valid = 2'b00;
    tick();
    n_cmp++; if (rsp_valid !== 2'b01 || rsp_result0 !== 64'h8000_0000_0000_0000 || rsp_flags0 !== 4'b1010) begin n_bad++; $display("FAIL ovf_result got=%b %h %b want=01 8000000000000000 1010", rsp_valid, rsp_result0, rsp_flags0); end
    tick();
  endtask

  task automatic test_backpressure();
    int g1;
    g1 = 0;
    rsp_ready = 2'b10; req_valid = 2'b01; req_op0 = 3'b100; req_a0 = 64'hF0; req_b0 = 64'h3C;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL bp_grant got=%b want=01", req_ready); end
    tick(); tick();
    req_valid = 2'b11; req_op1 = 3'b101; req_a1 = 64'd1; req_b1 = 64'd2;
    for (int k = 0; k < 10; k++) begin
      #1;
      n_cmp++; if (req_ready[0] !== 1'b0 || rsp_valid[0] !== 1'b1 || rsp_result0 !== 64'h30) begin n_bad++; $display("FAIL bp_hold[%0d] got=%b %b %h want=0 1 30", k, req_ready[0], rsp_valid[0], rsp_result0); end
      if (req_ready[1] === 1'b1) g1++;
      tick();
    end
    n_cmp++; if (g1 !== 4) begin n_bad++; $display("FAIL bp_r1_grants got=%0d want=4", g1); end
    n_cmp++; if (rsp_result1 !== 64'd3) begin n_bad++; $display("FAIL bp_r1_result got=%h want=3", rsp_result1); end
    rsp_ready = 2'b11;
    #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL bp_release_same got=%b want=00", req_ready); end
    tick();
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL bp_release_next got=%b want=01", req_ready); end
    tick(); req_valid = 2'b00;
    tick(); tick(); tick();
  endtask

  task automatic test_illegal_sat();
    reset_n = 1'b0;
    #1;
    @(negedge clk) reset_n = 1'b1;
    tick();
    rsp_ready = 2'b11; req_valid = 2'b01; req_op0 = 3'b101; req_a0 = 64'd1; req_b0 = 64'd2;
    tick(); req_valid = 2'b00;
    tick(); tick();
    req_valid = 2'b01; req_op0 = 3'b111; req_a0 = 64'hAAAA; req_b0 = 64'h5555;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL ill_grant got=%b want=01", req_ready); end
    tick(); req_valid = 2'b00;
    n_cmp++; if (alu_a !== 64'd1 || alu_b !== 64'd2 || alu_cntrl !== 3'b101) begin n_bad++; $display("FAIL ill_alu_hold got=%h %h %b want=1 2 101", alu_a, alu_b, alu_cntrl); end
    n_cmp++; if (grant_cnt0 !== 2'd2) begin n_bad++; $display("FAIL ill_cnt got=%0d want=2", grant_cnt0); end
    tick();
    n_cmp++; if (rsp_valid !== 2'b01 || rsp_err !== 2'b01 || rsp_result0 !== 64'd0 || rsp_flags0 !== 4'd0) begin n_bad++; $display("FAIL ill_rsp got=%b %b %h %b want=01 01 0 0000", rsp_valid, rsp_err, rsp_result0, rsp_flags0); end
    tick();
    n_cmp++; if (rsp_valid !== 2'b00 || rsp_err !== 2'b00) begin n_bad++; $display("FAIL ill_clear got=%b %b want=00 00", rsp_valid, rsp_err); end
    for (int k = 0; k < 3; k++) begin
      req_valid = 2'b01; req_op0 = 3'b010; req_a0 = 64'(k); req_b0 = 64'd1;
      tick(); req_valid = 2'b00;
      tick(); tick();
    end
    n_cmp++; if (grant_cnt0 !== 2'd3 || grant_cnt1 !== 2'd0) begin n_bad++; $display("FAIL sat_cnt got=%0d/%0d want=3/0", grant_cnt0, grant_cnt1); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0; req_op0 = '0; req_op1 = '0;
    test_reset();
    test_single_add();
    test_reset_midrun();
    test_contention();
    test_overflow();
    test_backpressure();
    test_illegal_sat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
